// File: rtl/boid_frame_sched.sv
// Per-frame sequencer for the boid update datapath: self read, neighbour stream, write-back per boid.
// One read outstanding; rd/wr requests hold until accepted, read data may arrive any cycle >= 1 after accept.
module boid_frame_sched #(
    parameter int NUM_BOIDS = 4,
    parameter int AW        = (NUM_BOIDS > 1) ? $clog2(NUM_BOIDS) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    output logic          rd_req,
    output logic [AW-1:0] rd_addr,
    input  logic          rd_ready,
    input  logic          rd_valid,
    output logic          acc_clr,
    output logic          self_ld,
    output logic          dp_en,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    input  logic          wr_ready,
    output logic          busy,
    output logic          done
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SELF_RD,
        S_SELF_WAIT,
        S_NB_RD,
        S_NB_WAIT,
        S_WB,
        S_DONE
    } state_t;

    localparam logic [AW:0] W_NUM  = (AW+1)'(NUM_BOIDS);
    localparam logic [AW:0] W_LAST = (AW+1)'(NUM_BOIDS - 1);
    localparam logic [AW:0] W_ONE  = (AW+1)'(1);
    localparam logic [AW:0] W_TWO  = (AW+1)'(2);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_en_q;
    logic [AW:0] r_boid_i;
    logic [AW:0] r_nb_j;
    logic [AW:0] w_boid_i_nxt;
    logic [AW:0] w_nb_j_nxt;
    logic        w_start;
    logic [AW:0] w_first_nb;
    logic [AW:0] w_nb_inc;
    logic [AW:0] w_nb_next;

    assign w_start = r_en_q & ~en;

    // Neighbour walk is ascending j with j == i skipped, so a step is +1 or +2.
    assign w_first_nb = (r_boid_i == '0) ? W_ONE : '0;
    assign w_nb_inc   = r_nb_j + W_ONE;
    assign w_nb_next  = (w_nb_inc == r_boid_i) ? (r_nb_j + W_TWO) : w_nb_inc;

    always_comb begin
        w_state_nxt  = r_state;
        w_boid_i_nxt = r_boid_i;
        w_nb_j_nxt   = r_nb_j;
        rd_req       = 1'b0;
        rd_addr      = '0;
        acc_clr      = 1'b0;
        self_ld      = 1'b0;
        dp_en        = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (w_start) begin
                    w_boid_i_nxt = '0;
                    w_state_nxt  = S_SELF_RD;
                end
            end
            S_SELF_RD: begin
                acc_clr = 1'b1;
                rd_req  = 1'b1;
                rd_addr = r_boid_i[AW-1:0];
                if (rd_ready) begin
                    w_state_nxt = S_SELF_WAIT;
                end
            end
            S_SELF_WAIT: begin
                self_ld = rd_valid;
                if (rd_valid) begin
                    if (w_first_nb < W_NUM) begin
                        w_nb_j_nxt  = w_first_nb;
                        w_state_nxt = S_NB_RD;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_NB_RD: begin
                rd_req  = 1'b1;
                rd_addr = r_nb_j[AW-1:0];
                if (rd_ready) begin
                    w_state_nxt = S_NB_WAIT;
                end
            end
            S_NB_WAIT: begin
                dp_en = rd_valid;
                if (rd_valid) begin
                    if (w_nb_next < W_NUM) begin
                        w_nb_j_nxt  = w_nb_next;
                        w_state_nxt = S_NB_RD;
                    end else begin
                        w_state_nxt = S_WB;
                    end
                end
            end
            S_WB: begin
                wr_en   = 1'b1;
                wr_addr = r_boid_i[AW-1:0];
                if (wr_ready) begin
                    if (r_boid_i == W_LAST) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_boid_i_nxt = r_boid_i + W_ONE;
                        w_state_nxt  = S_SELF_RD;
                    end
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_en_q   <= 1'b0;
            r_boid_i <= '0;
            r_nb_j   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_en_q   <= en;
            r_boid_i <= w_boid_i_nxt;
            r_nb_j   <= w_nb_j_nxt;
        end
    end

endmodule

// File: tb/tb_boid_frame_sched.sv
// Bench for boid_frame_sched: reactive memory model with random latency/stalls, checked against
// the expected per-frame transaction order built directly from the boid/neighbour rules.
module tb_boid_frame_sched;
    localparam int NB  = 4;
    localparam int AWT = 2;
    localparam int EV_R = 1000;
    localparam int EV_S = 2000;
    localparam int EV_D = 3000;
    localparam int EV_W = 4000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic en = 1'b0, rd_ready = 1'b0, rd_valid = 1'b0, wr_ready = 1'b0;
    logic rd_req, acc_clr, self_ld, dp_en, wr_en, busy, done;
    logic [AWT-1:0] rd_addr, wr_addr;

    logic one_en = 1'b0, one_rd_ready = 1'b0, one_rd_valid = 1'b0, one_wr_ready = 1'b0;
    logic one_rd_req, one_acc_clr, one_self_ld, one_dp_en, one_wr_en, one_busy, one_done;
    logic [0:0] one_rd_addr, one_wr_addr;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    boid_frame_sched #(.NUM_BOIDS(NB)) u_dut (
        .clk(clk), .reset(reset), .en(en),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid),
        .acc_clr(acc_clr), .self_ld(self_ld), .dp_en(dp_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_ready(wr_ready),
        .busy(busy), .done(done)
    );

    boid_frame_sched #(.NUM_BOIDS(1)) u_one (
        .clk(clk), .reset(reset), .en(one_en),
        .rd_req(one_rd_req), .rd_addr(one_rd_addr), .rd_ready(one_rd_ready), .rd_valid(one_rd_valid),
        .acc_clr(one_acc_clr), .self_ld(one_self_ld), .dp_en(one_dp_en),
        .wr_en(one_wr_en), .wr_addr(one_wr_addr), .wr_ready(one_wr_ready),
        .busy(one_busy), .done(one_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int t;
        reset = 1'b1;
        en = 1'b0;
        rd_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (k == 3) en = 1'b1;
            @(negedge clk);
            checks++;
            if ({rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done} !== '0)
                begin errors++; $display("FAIL reset_outputs k=%0d got=%h want=0", k,
                    {rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done}); end
        end
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            checks++;
            if ({rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done} !== '0)
                begin errors++; $display("FAIL idle_en_high k=%0d got=%h want=0", k,
                    {rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done}); end
        end
        step();
        en = 1'b0;
        t = cyc;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_cycle_busy got=%b want=0", busy); end
        step();
        @(negedge clk);
        checks++;
        if ({rd_req, rd_addr, acc_clr, busy} !== {1'b1, 2'd0, 1'b1, 1'b1} || cyc != t + 1)
            begin errors++; $display("FAIL start_latency got req/addr/clr/busy=%b%0d%b%b want=1011",
                rd_req, rd_addr, acc_clr, busy); end
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int lat_min, input int lat_max,
                             input int rdy_pct, input int spur_pct,
                             input int srd_idx, input int srd_n,
                             input int swr_idx, input int swr_n, input bit poke_en);
        int exp_q[$];
        int obs_q[$];
        int t, c, stalls, rd_acc, wr_acc, rd_held, wr_held, due, out_addr, done_cyc, lat;
        bit outst, seen_done, prv_rs, prv_ws;
        logic [AWT-1:0] prv_ra, prv_wa;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back(EV_R + i);
            exp_q.push_back(EV_S + i);
            for (int j = 0; j < NB; j++) begin
                if (j != i) begin
                    exp_q.push_back(EV_R + j);
                    exp_q.push_back(EV_D + j);
                end
            end
            exp_q.push_back(EV_W + i);
        end
        stalls = 0; rd_acc = 0; wr_acc = 0; rd_held = 0; wr_held = 0;
        due = 0; out_addr = 0; done_cyc = 0;
        outst = 1'b0; seen_done = 1'b0; prv_rs = 1'b0; prv_ws = 1'b0;
        prv_ra = '0; prv_wa = '0;
        step();
        en = 1'b1;
        rd_valid = 1'b0;
        step();
        en = 1'b0;
        t = cyc;
        for (int k = 0; k < 3000 && !seen_done; k++) begin
            step();
            c = cyc;
            rd_valid = outst ? (c == due) : ($urandom_range(99) < spur_pct);
            if (rd_req && rd_acc == srd_idx && rd_held < srd_n) begin
                rd_ready = 1'b0;
                rd_held++;
            end else rd_ready = ($urandom_range(99) < rdy_pct);
            if (wr_en && wr_acc == swr_idx && wr_held < swr_n) begin
                wr_ready = 1'b0;
                wr_held++;
            end else wr_ready = ($urandom_range(99) < rdy_pct);
            if (poke_en) en = (c == t + 5);
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL %s busy_in_frame cyc=%0d got=%b want=1", tag, c - t, busy); end
            if (prv_rs) begin
                checks++;
                if (rd_req !== 1'b1 || rd_addr !== prv_ra) begin errors++;
                    $display("FAIL %s rd_hold got=%b/%0d want=1/%0d", tag, rd_req, rd_addr, prv_ra); end
            end
            if (prv_ws) begin
                checks++;
                if (wr_en !== 1'b1 || wr_addr !== prv_wa) begin errors++;
                    $display("FAIL %s wr_hold got=%b/%0d want=1/%0d", tag, wr_en, wr_addr, prv_wa); end
            end
            if (outst && rd_valid) begin
                if (self_ld) obs_q.push_back(EV_S + out_addr);
                if (dp_en) obs_q.push_back(EV_D + out_addr);
                outst = 1'b0;
            end else begin
                checks++;
                if (self_ld || dp_en) begin errors++;
                    $display("FAIL %s spurious_ld cyc=%0d got=%b%b want=00", tag, c - t, self_ld, dp_en); end
            end
            if (rd_req && rd_ready) begin
                obs_q.push_back(EV_R + int'(rd_addr));
                outst = 1'b1;
                out_addr = int'(rd_addr);
                lat = $urandom_range(lat_max, lat_min);
                due = c + lat;
                stalls += lat - 1;
                rd_acc++;
            end
            prv_rs = rd_req && !rd_ready;
            prv_ra = rd_addr;
            if (prv_rs) stalls++;
            if (wr_en && wr_ready) begin
                obs_q.push_back(EV_W + int'(wr_addr));
                wr_acc++;
            end
            prv_ws = wr_en && !wr_ready;
            prv_wa = wr_addr;
            if (prv_ws) stalls++;
            if (done) begin
                seen_done = 1'b1;
                done_cyc = c;
            end
        end
        en = 1'b0;
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL %s done_timeout got=none want=cycle %0d", tag, 1 + NB * (2 * NB + 1) + stalls);
        end else if (done_cyc != t + 1 + NB * (2 * NB + 1) + stalls) begin
            errors++;
            $display("FAIL %s done_cycle got=t+%0d want=t+%0d", tag, done_cyc - t, 1 + NB * (2 * NB + 1) + stalls);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin errors++;
            $display("FAIL %s event_count got=%0d want=%0d", tag, obs_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size(); k++) begin
            checks++;
            if (k >= obs_q.size() || obs_q[k] != exp_q[k]) begin errors++;
                $display("FAIL %s event[%0d] got=%0d want=%0d", tag, k,
                         (k < obs_q.size()) ? obs_q[k] : -1, exp_q[k]); end
        end
        for (int k = 0; k < 4; k++) begin
            step();
            rd_valid = $urandom_range(1, 0);
            @(negedge clk);
            checks++;
            if ({rd_req, acc_clr, self_ld, dp_en, wr_en, busy, done} !== '0) begin errors++;
                $display("FAIL %s post_idle k=%0d got=%b want=0", tag, k,
                         {rd_req, acc_clr, self_ld, dp_en, wr_en, busy, done}); end
        end
        rd_valid = 1'b0;
    endtask

    task automatic test_zero_wait();
        run_frame("zero_wait", 1, 1, 100, 0, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_rd_stall();
        run_frame("rd_stall", 1, 1, 100, 0, 1, 3, -1, 0, 1'b0);
    endtask

    task automatic test_latency();
        for (int k = 0; k < 4; k++) begin
            step();
            rd_valid = (k % 2 == 0);
            @(negedge clk);
            checks++;
            if ({self_ld, dp_en, busy} !== 3'b000) begin errors++;
                $display("FAIL idle_rd_valid k=%0d got=%b want=000", k, {self_ld, dp_en, busy}); end
        end
        run_frame("lat4", 4, 4, 100, 50, -1, 0, -1, 0, 1'b0);
    endtask

    task automatic test_wr_stall();
        run_frame("wr_stall", 1, 1, 100, 0, -1, 0, 2, 2, 1'b0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) run_frame("random", 1, 4, 60, 30, -1, 0, -1, 0, 1'b1);
    endtask

    task automatic test_reset_midframe();
        int t;
        bit acc_prev;
        rd_ready = 1'b1;
        wr_ready = 1'b1;
        rd_valid = 1'b0;
        acc_prev = 1'b0;
        step();
        en = 1'b1;
        step();
        en = 1'b0;
        t = cyc;
        for (int k = 1; k <= 12; k++) begin
            step();
            rd_valid = acc_prev;
            @(negedge clk);
            acc_prev = rd_req && rd_ready;
        end
        step();
        rd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rd_req, wr_en, dp_en} !== 4'b1000) begin errors++;
            $display("FAIL nb_wait_state got busy/req/wr/dp=%b want=1000", {busy, rd_req, wr_en, dp_en}); end
        step();
        reset = 1'b0;
        rd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done} !== '0) begin errors++;
            $display("FAIL after_reset_late_valid got=%h want=0",
                     {rd_req, rd_addr, acc_clr, self_ld, dp_en, wr_en, wr_addr, busy, done}); end
        step();
        rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({rd_req, busy, done} !== 3'b000) begin errors++;
            $display("FAIL after_reset_idle got=%b want=000", {rd_req, busy, done}); end
        run_frame("restart", 1, 1, 100, 0, -1, 0, -1, 0, 1'b1);
    endtask

    task automatic test_single_boid();
        one_rd_ready = 1'b1;
        one_wr_ready = 1'b1;
        step();
        one_en = 1'b1;
        step();
        one_en = 1'b0;
        step();
        @(negedge clk);
        checks++;
        if ({one_rd_req, one_acc_clr, one_rd_addr, one_busy} !== 4'b1101) begin errors++;
            $display("FAIL one_self_rd got=%b want=1101", {one_rd_req, one_acc_clr, one_rd_addr, one_busy}); end
        step();
        one_rd_valid = 1'b1;
        @(negedge clk);
        checks++;
        if ({one_self_ld, one_dp_en, one_rd_req} !== 3'b100) begin errors++;
            $display("FAIL one_self_wait got=%b want=100", {one_self_ld, one_dp_en, one_rd_req}); end
        step();
        one_rd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({one_wr_en, one_wr_addr, one_dp_en, one_rd_req} !== 4'b1000) begin errors++;
            $display("FAIL one_wb got=%b want=1000", {one_wr_en, one_wr_addr, one_dp_en, one_rd_req}); end
        step();
        @(negedge clk);
        checks++;
        if ({one_done, one_busy, one_dp_en, one_self_ld} !== 4'b1100) begin errors++;
            $display("FAIL one_done got=%b want=1100", {one_done, one_busy, one_dp_en, one_self_ld}); end
        step();
        @(negedge clk);
        checks++;
        if ({one_done, one_busy, one_wr_en} !== 3'b000) begin errors++;
            $display("FAIL one_idle got=%b want=000", {one_done, one_busy, one_wr_en}); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_rd_stall();
        test_latency();
        test_wr_stall();
        test_random();
        test_reset_midframe();
        test_single_boid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
